// File: rtl/flofifo_pkg.sv
// Shared width helpers for the multi-channel FIFO slice.
package flofifo_pkg;

    // Count width: one extra bit so a full channel (locs == DEPTH) is representable.
    function automatic int cw_f(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int chw_f(input int nchan);
        return (nchan > 1) ? $clog2(nchan) : 1;
    endfunction

    localparam int NCHAN_DEF = 4;
    localparam int DEPTH_DEF = 32;
    localparam int WIDTH_DEF = 32;
    localparam int CW_DEF    = cw_f(DEPTH_DEF);
    localparam int CHW_DEF   = chw_f(NCHAN_DEF);

endpackage

// File: rtl/flofifo_mc_if.sv
// Write/read/status bundle for flofifo_mc. afull_o exists only with FLOFIFO_MC_AFULL_EN.
interface flofifo_mc_if import flofifo_pkg::*; #(
    parameter int NCHAN = NCHAN_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int WIDTH = WIDTH_DEF
) ();
    localparam int CW  = cw_f(DEPTH);
    localparam int CHW = chw_f(NCHAN);

    logic [WIDTH-1:0]    data_i;
    logic [CHW-1:0]      wchan_i;
    logic                valid_i;
    logic [CHW-1:0]      rchan_i;
    logic                read_i;
    logic [NCHAN-1:0]    flush_i;
    logic [WIDTH-1:0]    data_o;
    logic                valid_o;
    logic [CHW-1:0]      rchan_o;
    logic [NCHAN*CW-1:0] locs_o;
    logic [NCHAN-1:0]    empty_o;
    logic [NCHAN-1:0]    full_o;
    logic [NCHAN-1:0]    ovf_o;
    logic [NCHAN-1:0]    udf_o;
`ifdef FLOFIFO_MC_AFULL_EN
    logic [NCHAN-1:0]    afull_o;
`endif

    modport slave (
        input  data_i, wchan_i, valid_i, rchan_i, read_i, flush_i,
        output data_o, valid_o, rchan_o, locs_o, empty_o, full_o, ovf_o, udf_o
`ifdef FLOFIFO_MC_AFULL_EN
        , output afull_o
`endif
    );

    modport master (
        output data_i, wchan_i, valid_i, rchan_i, read_i, flush_i,
        input  data_o, valid_o, rchan_o, locs_o, empty_o, full_o, ovf_o, udf_o
`ifdef FLOFIFO_MC_AFULL_EN
        , input afull_o
`endif
    );
endinterface

// File: rtl/flofifo_ram.sv
// Simple dual-port RAM, one write port and one registered read port, no reset.
module flofifo_ram #(
    parameter int WORDS = 128,
    parameter int AW    = 7,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem [WORDS];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/flofifo_mc.sv
// NCHAN independent FIFOs sharing one RAM, with sticky ovf/udf and per-channel flush.
// Optional almost-full output under FLOFIFO_MC_AFULL_EN.
module flofifo_mc import flofifo_pkg::*; #(
    parameter int NCHAN = NCHAN_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int WIDTH = WIDTH_DEF,
    parameter int AFULL = 28
) (
    input  logic          clk,
    input  logic          rst,
    flofifo_mc_if.slave   bus
);
    localparam int PW  = $clog2(DEPTH);
    localparam int CW  = cw_f(DEPTH);
    localparam int CHW = chw_f(NCHAN);
    localparam int AW  = CHW + PW;

    if (NCHAN < 1 || DEPTH < 2 || (1 << PW) != DEPTH) begin : g_bad_cfg
        $error("flofifo_mc: NCHAN >= 1 and DEPTH a power of two >= 2 required");
    end

    logic [NCHAN-1:0]         wsel, rsel, wr_ok, rd_ok, full, empty, ovf_q, udf_q;
    logic [NCHAN-1:0][CW-1:0] locs_q;
    logic [NCHAN-1:0][PW-1:0] wptr_q, rptr_q;
    logic [PW-1:0]            wptr_sel, rptr_sel;
    logic [WIDTH-1:0]         ram_rdata;
    logic                     vld_q;
    logic [CHW-1:0]           rchan_q;

    for (genvar c = 0; c < NCHAN; c++) begin : g_chan
        // Out-of-range selects never match any channel, so they are silently ignored.
        assign wsel[c]  = bus.valid_i && (bus.wchan_i == CHW'(c));
        assign rsel[c]  = bus.read_i  && (bus.rchan_i == CHW'(c));
        assign empty[c] = (locs_q[c] == '0);
        assign full[c]  = (locs_q[c] == CW'(DEPTH));
        assign rd_ok[c] = rsel[c] & ~empty[c] & ~bus.flush_i[c];
        assign wr_ok[c] = wsel[c] & ~bus.flush_i[c] & (~full[c] | rd_ok[c]);

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                wptr_q[c] <= '0;
                rptr_q[c] <= '0;
                locs_q[c] <= '0;
                ovf_q[c]  <= 1'b0;
                udf_q[c]  <= 1'b0;
            end else if (bus.flush_i[c]) begin
                wptr_q[c] <= '0;
                rptr_q[c] <= '0;
                locs_q[c] <= '0;
                ovf_q[c]  <= 1'b0;
                udf_q[c]  <= 1'b0;
            end else begin
                if (wr_ok[c]) wptr_q[c] <= wptr_q[c] + PW'(1);
                if (rd_ok[c]) rptr_q[c] <= rptr_q[c] + PW'(1);
                locs_q[c] <= locs_q[c] + CW'(wr_ok[c]) - CW'(rd_ok[c]);
                if (wsel[c] && !wr_ok[c]) ovf_q[c] <= 1'b1;
                if (rsel[c] && empty[c])  udf_q[c] <= 1'b1;
            end
        end
    end

    always_comb begin
        wptr_sel = '0;
        rptr_sel = '0;
        for (int c = 0; c < NCHAN; c++) begin
            if (wsel[c]) wptr_sel = wptr_q[c];
            if (rsel[c]) rptr_sel = rptr_q[c];
        end
    end

    flofifo_ram #(.WORDS(NCHAN*DEPTH), .AW(AW), .WIDTH(WIDTH)) u_ram (
        .clk   (clk),
        .we    (|wr_ok),
        .waddr ({bus.wchan_i, wptr_sel}),
        .wdata (bus.data_i),
        .re    (|rd_ok),
        .raddr ({bus.rchan_i, rptr_sel}),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q   <= 1'b0;
            rchan_q <= '0;
        end else begin
            vld_q <= |rd_ok;
            if (|rd_ok) rchan_q <= bus.rchan_i;
        end
    end

    // RAM output has no reset; gating with valid gives data_o = 0 out of reset.
    assign bus.data_o  = vld_q ? ram_rdata : '0;
    assign bus.valid_o = vld_q;
    assign bus.rchan_o = rchan_q;
    assign bus.locs_o  = locs_q;
    assign bus.empty_o = empty;
    assign bus.full_o  = full;
    assign bus.ovf_o   = ovf_q;
    assign bus.udf_o   = udf_q;

`ifdef FLOFIFO_MC_AFULL_EN
    if (AFULL > DEPTH) begin : g_bad_afull
        $error("flofifo_mc: AFULL must not exceed DEPTH");
    end
    for (genvar c = 0; c < NCHAN; c++) begin : g_afull
        assign bus.afull_o[c] = (locs_q[c] >= CW'(AFULL));
    end
`endif
endmodule

// File: tb/tb_flofifo_mc.sv
// Scoreboard bench for flofifo_mc: directed plan items plus randomized traffic vs a queue model.
module tb_flofifo_mc;
    localparam int NC    = 4;
    localparam int DEPTH = 32;
    localparam int WIDTH = 32;
    localparam int AFULL = 28;
    localparam int CW    = 6;
    localparam int CHW   = 2;

    typedef struct {
        bit               v;
        logic [WIDTH-1:0] d;
        int               ch;
        int               tgt;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    bit   mon_en = 1'b0;

    exp_t             sb[$];
    logic [WIDTH-1:0] mq[NC][$];
    bit   [NC-1:0]    m_ovf, m_udf;

    flofifo_mc_if #(.NCHAN(NC), .DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();
    flofifo_mc #(.NCHAN(NC), .DEPTH(DEPTH), .WIDTH(WIDTH), .AFULL(AFULL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_status();
        logic [NC*CW-1:0] locs;
        logic [NC-1:0]    emp, ful, af;
        for (int c = 0; c < NC; c++) begin
            locs[c*CW +: CW] = CW'(mq[c].size());
            emp[c] = (mq[c].size() == 0);
            ful[c] = (mq[c].size() == DEPTH);
            af[c]  = (mq[c].size() >= AFULL);
        end
        chk("locs_o", 256'(bus.locs_o), 256'(locs));
        chk("empty_o", 256'(bus.empty_o), 256'(emp));
        chk("full_o", 256'(bus.full_o), 256'(ful));
        chk("ovf_o", 256'(bus.ovf_o), 256'(m_ovf));
        chk("udf_o", 256'(bus.udf_o), 256'(m_udf));
`ifdef FLOFIFO_MC_AFULL_EN
        chk("afull_o", 256'(bus.afull_o), 256'(af));
`else
        if (af != af) chk("afull_unused", 256'(af), 256'(af));
`endif
    endtask

    // One clock of stimulus; the model is evaluated on the pre-edge state.
    task automatic step(input bit w, input int wc, input logic [WIDTH-1:0] wd,
                        input bit r, input int rc, input logic [NC-1:0] fl);
        bit   rok, wok;
        exp_t e;
        bus.valid_i = w;  bus.wchan_i = CHW'(wc); bus.data_i = wd;
        bus.read_i  = r;  bus.rchan_i = CHW'(rc); bus.flush_i = fl;
        rok = r && !fl[rc] && (mq[rc].size() > 0);
        wok = w && !fl[wc] && ((mq[wc].size() < DEPTH) || (rok && rc == wc));
        if (r) begin
            e.v = rok; e.d = rok ? mq[rc][0] : '0; e.ch = rc; e.tgt = cyc + 1;
            sb.push_back(e);
        end
        if (r && !fl[rc] && mq[rc].size() == 0) m_udf[rc] = 1'b1;
        if (w && !fl[wc] && !wok) m_ovf[wc] = 1'b1;
        if (rok) void'(mq[rc].pop_front());
        if (wok) mq[wc].push_back(wd);
        for (int c = 0; c < NC; c++)
            if (fl[c]) begin mq[c].delete(); m_ovf[c] = 1'b0; m_udf[c] = 1'b0; end
        @(posedge clk); #1;
        check_status();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, '0, 0, 0, '0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_valid_o"}, 256'(bus.valid_o), 256'(0));
        chk({tag, "_data_o"},  256'(bus.data_o), 256'(0));
        chk({tag, "_rchan_o"}, 256'(bus.rchan_o), 256'(0));
        chk({tag, "_locs_o"},  256'(bus.locs_o), 256'(0));
        chk({tag, "_empty_o"}, 256'(bus.empty_o), 256'({NC{1'b1}}));
        chk({tag, "_full_o"},  256'(bus.full_o), 256'(0));
        chk({tag, "_ovf_o"},   256'(bus.ovf_o), 256'(0));
        chk({tag, "_udf_o"},   256'(bus.udf_o), 256'(0));
    endtask

    // Monitor: pops one expectation per read, otherwise valid_o must stay low.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                while (sb.size() > 0 && sb[0].tgt < cyc) begin
                    e = sb.pop_front();
                    chk("stale_expect", 256'(e.tgt), 256'(cyc));
                end
                if (sb.size() > 0 && sb[0].tgt == cyc) begin
                    e = sb.pop_front();
                    chk("valid_o", 256'(bus.valid_o), 256'(e.v));
                    if (e.v) begin
                        chk("data_o", 256'(bus.data_o), 256'(e.d));
                        chk("rchan_o", 256'(bus.rchan_o), 256'(e.ch));
                    end
                end else begin
                    chk("idle_valid_o", 256'(bus.valid_o), 256'(0));
                end
            end
        end
    end

    initial begin
        bus.valid_i = 0; bus.wchan_i = '0; bus.data_i = '0;
        bus.read_i = 0;  bus.rchan_i = '0; bus.flush_i = '0;
        m_ovf = '0; m_udf = '0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        rst = 1'b0;
        mon_en = 1'b1;

        // single word round trip
        step(1, 0, 32'h1, 0, 0, '0);
        step(0, 0, '0, 1, 0, '0);
        idle(2);

        // fill ch2 past full, drain, then exercise pointer wrap
        for (int k = 0; k < 33; k++) step(1, 2, 32'(200 + k), 0, 0, '0);
        for (int k = 0; k < 32; k++) step(0, 0, '0, 1, 2, '0);
        for (int k = 0; k < 5; k++)  step(1, 2, 32'(500 + k), 0, 0, '0);
        for (int k = 0; k < 5; k++)  step(0, 0, '0, 1, 2, '0);
        step(0, 0, '0, 0, 0, 4'b0100);

        // interleave ch0 / ch3
        for (int k = 0; k < 10; k++) begin
            step(1, 0, 32'(100 + k), 0, 0, '0);
            step(1, 3, 32'(300 + k), 0, 0, '0);
        end
        for (int k = 0; k < 10; k++) begin
            step(0, 0, '0, 1, 3, '0);
            step(0, 0, '0, 1, 0, '0);
        end

        // boundaries on ch1
        step(0, 0, '0, 1, 1, '0);
        for (int k = 0; k < 32; k++) step(1, 1, 32'(700 + k), 0, 0, '0);
        step(1, 1, 32'h777, 1, 1, '0);
        for (int k = 0; k < 32; k++) step(0, 0, '0, 1, 1, '0);
        step(1, 1, 32'h888, 1, 1, '0);
        step(0, 0, '0, 1, 1, '0);

        // flush ch0 together with a write
        for (int k = 0; k < 5; k++) step(1, 0, 32'(40 + k), 0, 0, '0);
        step(1, 0, 32'hdead, 0, 0, 4'b0001);
        // read one cycle before a flush still completes
        step(1, 0, 32'h55, 0, 0, '0);
        step(0, 0, '0, 1, 0, '0);
        step(0, 0, '0, 0, 0, 4'b0001);
        idle(1);

        // almost-full threshold walk on ch3
        step(0, 0, '0, 0, 0, 4'b1000);
        for (int k = 0; k < AFULL; k++) step(1, 3, 32'(900 + k), 0, 0, '0);
        step(0, 0, '0, 1, 3, '0);
        step(0, 0, '0, 0, 0, 4'b1111);

        // randomized traffic, alternating write-heavy and read-heavy phases
        for (int ph = 0; ph < 6; ph++) begin
            for (int i = 0; i < 300; i++) begin
                int wp;
                logic [NC-1:0] fl;
                wp = ph[0] ? 25 : 80;
                fl = ($urandom_range(0, 99) < 2) ? NC'(1 << $urandom_range(0, NC-1)) : '0;
                step($urandom_range(0, 99) < wp, $urandom_range(0, NC-1), $urandom,
                     $urandom_range(0, 99) < (105 - wp), $urandom_range(0, NC-1), fl);
            end
        end
        idle(3);

        // reset in the middle of a read burst
        step(0, 0, '0, 0, 0, 4'b1111);
        step(0, 0, '0, 1, 1, '0);
        for (int k = 0; k < 6; k++) step(1, 0, 32'(60 + k), 0, 0, '0);
        step(0, 0, '0, 1, 0, '0);
        step(0, 0, '0, 1, 0, '0);
        chk("burst_valid_before_rst", 256'(bus.valid_o), 256'(1));
        mon_en = 1'b0;
        sb.delete();
        bus.read_i = 0;
        #1 rst = 1'b1;
        #1 check_reset_outputs("midrst");
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < NC; c++) mq[c].delete();
        m_ovf = '0; m_udf = '0;
        @(negedge clk);
        mon_en = 1'b1;
        step(1, 2, 32'habc, 0, 0, '0);
        step(0, 0, '0, 1, 2, '0);
        idle(3);

        chk("scoreboard_drained", 256'(sb.size()), 256'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
